// File: rtl/riscv_clint_mh.sv
// Multi-hart RISC-V core-local interruptor: shared mtime with prescaler,
// per-hart mtimecmp and MSIP, single-cycle registered read/write port.
module riscv_clint_mh #(
   parameter int NHARTS   = 4,
   parameter int TICK_DIV = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       addr,
   input  logic              req,
   input  logic              wren,
   output logic              gnt,
   input  logic [63:0]       wdata,
   input  logic [7:0]        wstrb,
   output logic [63:0]       rdata,
   output logic              rvalid,
   output logic [63:0]       out_mtime,
   output logic [NHARTS-1:0] out_MTIP,
   output logic [NHARTS-1:0] out_MSIP
);

   localparam logic [15:0] LP_PRE_MAX    = 16'(TICK_DIV - 1);
   localparam logic [31:0] LP_CMP_BASE   = 32'h0000_4000;
   localparam logic [31:0] LP_MTIME_ADDR = 32'h0000_BFF8;

   logic [63:0]       r_mtime;
   logic [15:0]       r_prescale;
   logic [63:0]       r_mtimecmp [NHARTS];
   logic [NHARTS-1:0] r_msip;
   logic [NHARTS-1:0] r_mtip;
   logic [63:0]       r_rdata;
   logic              r_rvalid;

   logic [31:0] w_dw;
   logic        w_wr;
   logic        w_mtime_wr;
   logic [63:0] w_mask;
   logic [63:0] w_rd;
   logic        w_unused_addr;

   assign w_dw          = {addr[31:3], 3'b000};
   assign w_unused_addr = ^addr[2:0];
   assign w_wr          = req & wren;
   assign w_mtime_wr    = w_wr & (w_dw == LP_MTIME_ADDR) & (|wstrb);

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_mask = '0;
      for (int b = 0; b < 8; b++) begin
         w_mask[8*b +: 8] = {8{wstrb[b]}};
      end
   end

   // Read mux; unmapped doublewords and absent harts fall through to zero.
   always_comb begin
      w_rd = '0;
      for (int h = 0; h < NHARTS; h++) begin
         if (w_dw == 32'((h / 2) * 8)) begin
            if (h % 2 == 0) w_rd[0]  = r_msip[h];
            else            w_rd[32] = r_msip[h];
         end
         if (w_dw == LP_CMP_BASE + 32'(h * 8)) begin
            w_rd = r_mtimecmp[h];
         end
      end
      if (w_dw == LP_MTIME_ADDR) begin
         w_rd = r_mtime;
      end
   end

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mtime    <= '0;
         r_prescale <= '0;
         // NOTE: mtimecmp must be reset (to all-ones) so no hart sees a spurious timer interrupt.
         for (int h = 0; h < NHARTS; h++) begin
            r_mtimecmp[h] <= '1;
         end
         r_msip   <= '0;
         r_mtip   <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= req;
         if (req) begin
            r_rdata <= w_rd;
         end

         for (int h = 0; h < NHARTS; h++) begin
            r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
         end

         // A software write to mtime wins over the tick and restarts the prescaler.
         if (w_mtime_wr) begin
            r_mtime    <= (r_mtime & ~w_mask) | (wdata & w_mask);
            r_prescale <= '0;
         end else if (r_prescale == LP_PRE_MAX) begin
            r_prescale <= '0;
            r_mtime    <= r_mtime + 64'd1;
         end else begin
            r_prescale <= r_prescale + 16'd1;
         end

         for (int h = 0; h < NHARTS; h++) begin
            if (w_wr && (w_dw == LP_CMP_BASE + 32'(h * 8))) begin
               r_mtimecmp[h] <= (r_mtimecmp[h] & ~w_mask) | (wdata & w_mask);
            end
            if (w_wr && (w_dw == 32'((h / 2) * 8))) begin
               if (h % 2 == 0) begin
                  if (wstrb[0]) r_msip[h] <= wdata[0];
               end else begin
                  if (wstrb[4]) r_msip[h] <= wdata[32];
               end
            end
         end
      end
   end

   assign gnt       = 1'b1;
   assign rdata     = r_rdata;
   assign rvalid    = r_rvalid;
   assign out_mtime = r_mtime;
   assign out_MTIP  = r_mtip;
   assign out_MSIP  = r_msip;

endmodule

// File: tb/tb_riscv_clint_mh.sv
// Bench for riscv_clint_mh: two instances (TICK_DIV=1 and 4) driven in parallel,
// directed scenarios then random traffic, all checked against a behavioural model.
module tb_riscv_clint_mh;

   localparam int NH = 4;
   localparam int DIV [2] = '{1, 4};

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        req;
   logic        wren;
   logic [63:0] wdata;
   logic [7:0]  wstrb;

   logic          gnt_w    [2];
   logic [63:0]   rdata_w  [2];
   logic          rvalid_w [2];
   logic [63:0]   mtime_w  [2];
   logic [NH-1:0] mtip_w   [2];
   logic [NH-1:0] msip_w   [2];

   riscv_clint_mh #(.NHARTS(NH), .TICK_DIV(1)) u_dut_div1 (
      .clk(clk), .rst(rst), .addr(addr), .req(req), .wren(wren), .gnt(gnt_w[0]),
      .wdata(wdata), .wstrb(wstrb), .rdata(rdata_w[0]), .rvalid(rvalid_w[0]),
      .out_mtime(mtime_w[0]), .out_MTIP(mtip_w[0]), .out_MSIP(msip_w[0])
   );

   riscv_clint_mh #(.NHARTS(NH), .TICK_DIV(4)) u_dut_div4 (
      .clk(clk), .rst(rst), .addr(addr), .req(req), .wren(wren), .gnt(gnt_w[1]),
      .wdata(wdata), .wstrb(wstrb), .rdata(rdata_w[1]), .rvalid(rvalid_w[1]),
      .out_mtime(mtime_w[1]), .out_MTIP(mtip_w[1]), .out_MSIP(msip_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state, one set per instance.
   logic [63:0]   m_mtime  [2];
   int            m_pre    [2];
   logic [63:0]   m_cmp    [2][NH];
   logic [NH-1:0] m_msip   [2];
   logic [NH-1:0] m_mtip   [2];
   logic [63:0]   m_rdata  [2];
   logic          m_rvalid [2];

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] addr_tbl [14] = '{32'h0000, 32'h0004, 32'h0008, 32'h000C, 32'h0010, 32'h0018,
                                  32'h4000, 32'h4008, 32'h4010, 32'h4018, 32'h4020, 32'h4038,
                                  32'hBFF8, 32'hBFF0};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                         input logic [7:0] s);
      logic [63:0] v;
      v = old;
      for (int b = 0; b < 8; b++) begin
         if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      end
      return v;
   endfunction

   function automatic logic [63:0] model_read(input int i, input logic [31:0] d);
      int  k;
      logic lo, hi;
      if (d == 32'hBFF8) return m_mtime[i];
      if (d >= 32'h4000 && d < 32'h4000 + 32'(8 * NH)) return m_cmp[i][(d - 32'h4000) / 8];
      if (d < 32'h4000) begin
         k  = int'(d / 8);
         lo = (2 * k < NH)     ? m_msip[i][2 * k]     : 1'b0;
         hi = (2 * k + 1 < NH) ? m_msip[i][2 * k + 1] : 1'b0;
         return {31'b0, hi, 31'b0, lo};
      end
      return 64'd0;
   endfunction

   task automatic model_step();
      logic [31:0]   d;
      logic [63:0]   rd;
      logic [NH-1:0] nmtip;
      logic          wr;
      int            k;
      d  = {addr[31:3], 3'b000};
      wr = req && wren;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_mtime[i]  = '0;
            m_pre[i]    = 0;
            for (int h = 0; h < NH; h++) m_cmp[i][h] = '1;
            m_msip[i]   = '0;
            m_mtip[i]   = '0;
            m_rdata[i]  = '0;
            m_rvalid[i] = 1'b0;
         end else begin
            rd = model_read(i, d);
            for (int h = 0; h < NH; h++) nmtip[h] = (m_mtime[i] >= m_cmp[i][h]);
            m_rvalid[i] = req;
            if (req) m_rdata[i] = rd;
            if (wr && d == 32'hBFF8 && wstrb != 8'h00) begin
               m_mtime[i] = merge(m_mtime[i], wdata, wstrb);
               m_pre[i]   = 0;
            end else begin
               m_pre[i] = (m_pre[i] + 1) % DIV[i];
               if (m_pre[i] == 0) m_mtime[i] = m_mtime[i] + 64'd1;
            end
            if (wr && d >= 32'h4000 && d < 32'h4000 + 32'(8 * NH)) begin
               k = int'((d - 32'h4000) / 8);
               m_cmp[i][k] = merge(m_cmp[i][k], wdata, wstrb);
            end
            if (wr && d < 32'h4000) begin
               k = int'(d / 8);
               if (wstrb[0] && 2 * k < NH)     m_msip[i][2 * k]     = wdata[0];
               if (wstrb[4] && 2 * k + 1 < NH) m_msip[i][2 * k + 1] = wdata[32];
            end
            m_mtip[i] = nmtip;
         end
      end
   endtask

   task automatic check_outputs();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("gnt%0d", i),    64'(gnt_w[i]),    64'd1);
         check($sformatf("mtime%0d", i),  mtime_w[i],       m_mtime[i]);
         check($sformatf("mtip%0d", i),   64'(mtip_w[i]),   64'(m_mtip[i]));
         check($sformatf("msip%0d", i),   64'(msip_w[i]),   64'(m_msip[i]));
         check($sformatf("rvalid%0d", i), 64'(rvalid_w[i]), 64'(m_rvalid[i]));
         check($sformatf("rdata%0d", i),  rdata_w[i],       m_rdata[i]);
      end
   endtask

   task automatic drive(input logic r, input logic w, input logic [31:0] a,
                        input logic [63:0] d, input logic [7:0] s);
      req   = r;
      wren  = w;
      addr  = a;
      wdata = d;
      wstrb = s;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      cycle();
      cycle();
      check("rst_mtime", mtime_w[0], 64'd0);
      check("rst_rvalid", 64'(rvalid_w[0]), 64'd0);
      rst = 1'b0;

      // Free-running count after reset.
      for (int n = 0; n < 10; n++) cycle();
      check("mtime_10", mtime_w[0], 64'd10);
      check("mtip_idle", 64'(mtip_w[0]), 64'd0);
      check("msip_idle", 64'(msip_w[0]), 64'd0);
      cycle();
      cycle();
      check("div4_mtime_12", mtime_w[1], 64'd3);

      drive(1'b1, 1'b0, 32'h4000, 64'h0, 8'h00);
      cycle();
      check("cmp0_rst_rd", rdata_w[0], 64'hFFFF_FFFF_FFFF_FFFF);
      check("cmp0_rvalid", 64'(rvalid_w[0]), 64'd1);

      // mtime write mid prescaler count.
      drive(1'b1, 1'b1, 32'hBFF8, 64'h100, 8'hFF);
      cycle();
      idle();
      check("div4_wr_hold0", mtime_w[1], 64'h100);
      for (int n = 1; n < 4; n++) begin
         cycle();
         check("div4_wr_hold", mtime_w[1], 64'h100);
      end
      cycle();
      check("div4_wr_inc", mtime_w[1], 64'h101);
      check("div1_wr_inc", mtime_w[0], 64'h104);

      // mtimecmp[2] a few ticks ahead of mtime.
      drive(1'b1, 1'b1, 32'h4010, m_mtime[0] + 64'd5, 8'hFF);
      cycle();
      idle();
      for (int n = 1; n <= 4; n++) begin
         cycle();
         check("mtip2_before", 64'(mtip_w[0]), 64'd0);
      end
      cycle();
      check("mtip2_rise", 64'(mtip_w[0]), 64'h4);
      drive(1'b1, 1'b1, 32'h4010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      cycle();
      idle();
      check("mtip2_hold", 64'(mtip_w[0]), 64'h4);
      cycle();
      check("mtip2_clear", 64'(mtip_w[0]), 64'h0);

      // MSIP lanes for harts 2 and 3, then unmapped hart 4.
      drive(1'b1, 1'b1, 32'h0008, 64'h1_0000_0001, 8'h11);
      cycle();
      check("msip_23", 64'(msip_w[0]), 64'hC);
      drive(1'b1, 1'b0, 32'h000C, 64'h0, 8'h00);
      cycle();
      check("msip_rd", rdata_w[0], 64'h0000_0001_0000_0001);
      drive(1'b1, 1'b0, 32'h0010, 64'h0, 8'h00);
      cycle();
      check("hart4_rd", rdata_w[0], 64'h0);

      // mtime wrap with mtimecmp[0]=0.
      drive(1'b1, 1'b1, 32'h4000, 64'h0, 8'hFF);
      cycle();
      idle();
      cycle();
      check("mtip0_set", 64'(mtip_w[0][0]), 64'd1);
      drive(1'b1, 1'b1, 32'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
      cycle();
      idle();
      check("wrap_fe", mtime_w[0], 64'hFFFF_FFFF_FFFF_FFFE);
      check("wrap_mtip_a", 64'(mtip_w[0][0]), 64'd1);
      cycle();
      check("wrap_ff", mtime_w[0], 64'hFFFF_FFFF_FFFF_FFFF);
      cycle();
      check("wrap_0", mtime_w[0], 64'h0);
      check("wrap_mtip_b", 64'(mtip_w[0][0]), 64'd1);

      // Partial strobe to mtimecmp[1]; the write cycle returns the old value.
      drive(1'b1, 1'b1, 32'h4008, 64'h0, 8'h0F);
      cycle();
      check("part_old_rd", rdata_w[0], 64'hFFFF_FFFF_FFFF_FFFF);
      check("part_rvalid", 64'(rvalid_w[0]), 64'd1);
      drive(1'b1, 1'b0, 32'h4008, 64'h0, 8'h00);
      cycle();
      check("part_new_rd", rdata_w[0], 64'hFFFF_FFFF_0000_0000);

      // A request during reset is dropped.
      rst = 1'b1;
      drive(1'b1, 1'b1, 32'hBFF8, 64'h55, 8'hFF);
      cycle();
      check("rst_req_rvalid", 64'(rvalid_w[0]), 64'd0);
      check("rst_req_mtime", mtime_w[0], 64'd0);
      rst = 1'b0;
      idle();

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         rst   = ($urandom_range(0, 63) == 0);
         req   = ($urandom_range(0, 3) != 0);
         wren  = ($urandom_range(0, 1) == 1);
         addr  = addr_tbl[$urandom_range(0, 13)] | 32'($urandom_range(0, 7));
         wdata = {$urandom, $urandom};
         wstrb = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
         if (addr[31:3] == 29'(32'hBFF8 >> 3) && $urandom_range(0, 3) != 0) begin
            wdata = {32'h0, $urandom_range(0, 64)};
            wstrb = 8'hFF;
         end
         if (addr >= 32'h4000 && addr < 32'h4020 && $urandom_range(0, 1) == 0) begin
            wdata = m_mtime[$urandom_range(0, 1)] + 64'($urandom_range(0, 6));
            wstrb = 8'hFF;
         end
         cycle();
      end

      rst = 1'b0;
      idle();
      cycle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
